// File: rtl/dcache_refill_ctrl_pkg.sv
// Shared types and constants for the data-cache refill controller.
// Holds the controller state encoding and the doubleword alignment helper.
package dcache_refill_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    MEM_WAIT,
    RESP
  } state_t;

  localparam logic [63:0] DW_ALIGN = 64'hFFFF_FFFF_FFFF_FFF8;

  function automatic logic [63:0] dwAlign(input logic [63:0] addr);
    return addr & DW_ALIGN;
  endfunction

endpackage

// File: rtl/dcache_refill_ctrl_sat_counter.sv
// Saturating up-counter used for the cache hit/miss statistics.
// Holds at all-ones instead of wrapping so long runs never read back as small counts.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Load/store controller between the core, a direct-indexed data cache and the memory bus.
// Loads refill on miss, stores write through and update the cache only on a hit.
module dcache_refill_ctrl
  import dcache_refill_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [63:0]      req_addr,
  input  logic [63:0]      req_wdata,
  input  logic [7:0]       req_wmask,
  output logic             resp_valid,
  output logic [63:0]      resp_rdata,
  output logic [63:0]      cache_raddr,
  input  logic             cache_hit,
  input  logic [63:0]      cache_rdata,
  output logic             cache_upd,
  output logic [63:0]      cache_upd_addr,
  output logic [63:0]      cache_upd_data,
  output logic             cache_wupd,
  output logic [63:0]      cache_wupd_addr,
  output logic [63:0]      cache_wdata,
  output logic [7:0]       cache_wmask,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_write,
  output logic [63:0]      mem_req_addr,
  output logic [63:0]      mem_req_wdata,
  output logic [7:0]       mem_req_wmask,
  input  logic             mem_resp_valid,
  input  logic [63:0]      mem_resp_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  state_t      r_state;
  logic        r_reqReady;
  logic        r_write;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_wmask;
  logic        r_hitFlag;
  logic [63:0] r_rdata;
  logic        r_respValid;
  logic        r_cacheUpd;
  logic        r_cacheWupd;
  logic        r_memReqValid;

  logic w_lookup;
  logic w_hitInc;
  logic w_missInc;

  // Every transaction walks IDLE -> LOOKUP -> (MEM_REQ -> MEM_WAIT ->) RESP -> IDLE,
  // with all strobes registered so the cache write lands in the same cycle as resp_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_reqReady    <= 1'b1;
      r_write       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wmask       <= '0;
      r_hitFlag     <= 1'b0;
      r_rdata       <= '0;
      r_respValid   <= 1'b0;
      r_cacheUpd    <= 1'b0;
      r_cacheWupd   <= 1'b0;
      r_memReqValid <= 1'b0;
    end else begin
      r_respValid <= 1'b0;
      r_cacheUpd  <= 1'b0;
      r_cacheWupd <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr     <= req_addr;
            r_write    <= req_write;
            r_wdata    <= req_wdata;
            r_wmask    <= req_wmask;
            r_reqReady <= 1'b0;
            r_state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_hitFlag <= cache_hit;
          if (!r_write && cache_hit) begin
            r_rdata     <= cache_rdata;
            r_respValid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_rdata       <= '0;
            r_memReqValid <= 1'b1;
            r_state       <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (mem_req_ready) begin
            r_memReqValid <= 1'b0;
            r_state       <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          // Cache writes wait for memory completion so the cache never runs ahead of memory.
          if (mem_resp_valid) begin
            if (!r_write) begin
              r_rdata <= mem_resp_rdata;
            end
            r_respValid <= 1'b1;
            r_cacheUpd  <= !r_write;
            r_cacheWupd <= r_write && r_hitFlag;
            r_state     <= RESP;
          end
        end
        RESP: begin
          r_reqReady <= 1'b1;
          r_state    <= IDLE;
        end
        default: begin
          r_reqReady <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign w_lookup  = (r_state == LOOKUP);
  assign w_hitInc  = w_lookup && cache_hit;
  assign w_missInc = w_lookup && !cache_hit;

  sat_counter #(.CNT_W(CNT_W)) u_hitCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_hitInc),
    .count (hit_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_missCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_missInc),
    .count (miss_cnt)
  );

  assign req_ready       = r_reqReady;
  assign resp_valid      = r_respValid;
  assign resp_rdata      = r_rdata;
  assign cache_raddr     = r_addr;
  assign cache_upd       = r_cacheUpd;
  assign cache_upd_addr  = r_addr;
  assign cache_upd_data  = r_rdata;
  assign cache_wupd      = r_cacheWupd;
  assign cache_wupd_addr = r_addr;
  assign cache_wdata     = r_wdata;
  assign cache_wmask     = r_wmask;
  assign mem_req_valid   = r_memReqValid;
  assign mem_req_write   = r_write;
  assign mem_req_addr    = dwAlign(r_addr);
  assign mem_req_wdata   = r_wdata;
  assign mem_req_wmask   = r_wmask;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Self-checking bench for dcache_refill_ctrl with a small cache model, a delayed
// memory model and a scoreboard of expected responses.
module tb_dcache_refill_ctrl;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [63:0]      req_addr;
  logic [63:0]      req_wdata;
  logic [7:0]       req_wmask;
  logic             resp_valid;
  logic [63:0]      resp_rdata;
  logic [63:0]      cache_raddr;
  logic             cache_hit;
  logic [63:0]      cache_rdata;
  logic             cache_upd;
  logic [63:0]      cache_upd_addr;
  logic [63:0]      cache_upd_data;
  logic             cache_wupd;
  logic [63:0]      cache_wupd_addr;
  logic [63:0]      cache_wdata;
  logic [7:0]       cache_wmask;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic             mem_req_write;
  logic [63:0]      mem_req_addr;
  logic [63:0]      mem_req_wdata;
  logic [7:0]       mem_req_wmask;
  logic             mem_resp_valid;
  logic [63:0]      mem_resp_rdata;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  typedef struct {
    logic [63:0] rdata;
    logic        upd;
    logic        wupd;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          lat;
  } exp_t;

  exp_t expQ[$];

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  int acceptCyc   = 0;
  int respCount   = 0;
  int updCount    = 0;
  int wupdCount   = 0;

  int          memDelay       = 3;
  int          stallLeft      = 0;
  int          memCd          = 0;
  int          memReqCount    = 0;
  int          memValidCycles = 0;
  logic [63:0] memData        = '0;
  logic        prevMemValid   = 1'b0;
  logic [63:0] lastMemAddr    = '0;
  logic        lastMemWrite   = 1'b0;
  logic [63:0] lastMemWdata   = '0;
  logic [7:0]  lastMemWmask   = '0;
  logic [63:0] snapAddr       = '0;
  logic        snapWrite      = 1'b0;
  logic [63:0] snapWdata      = '0;
  logic [7:0]  snapWmask      = '0;

  logic        mValid[4];
  logic [63:0] mAddr[4];
  logic [63:0] mData[4];
  int          mNext = 0;

  exp_t monE;
  int   monIdx;

  dcache_refill_ctrl #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_wmask       (req_wmask),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .cache_raddr     (cache_raddr),
    .cache_hit       (cache_hit),
    .cache_rdata     (cache_rdata),
    .cache_upd       (cache_upd),
    .cache_upd_addr  (cache_upd_addr),
    .cache_upd_data  (cache_upd_data),
    .cache_wupd      (cache_wupd),
    .cache_wupd_addr (cache_wupd_addr),
    .cache_wdata     (cache_wdata),
    .cache_wmask     (cache_wmask),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_write   (mem_req_write),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_req_wmask   (mem_req_wmask),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_rdata  (mem_resp_rdata),
    .hit_cnt         (hit_cnt),
    .miss_cnt        (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache model answers the probe combinationally, matching on the doubleword address.
  always_comb begin
    cache_hit   = 1'b0;
    cache_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (mValid[i] && (mAddr[i][63:3] == cache_raddr[63:3])) begin
        cache_hit   = 1'b1;
        cache_rdata = mData[i];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic int modelFind(input logic [63:0] a);
    for (int i = 0; i < 4; i++) begin
      if (mValid[i] && (mAddr[i][63:3] == a[63:3])) return i;
    end
    return -1;
  endfunction

  // Response monitor: pops the scoreboard on resp_valid and keeps the cache model in step.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (req_valid && req_ready) acceptCyc = cyc;
      if (cache_upd) updCount++;
      if (cache_wupd) wupdCount++;
      if (cache_upd && cache_wupd) checkOutput("bothStrobes", 64'd1, 64'd0);
      if (resp_valid) begin
        respCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedResp", 64'd1, 64'd0);
        end else begin
          monE = expQ.pop_front();
          checkOutput("respRdata", resp_rdata, monE.rdata);
          checkOutput("cacheUpd", 64'(cache_upd), 64'(monE.upd));
          checkOutput("cacheWupd", 64'(cache_wupd), 64'(monE.wupd));
          if (monE.upd) begin
            checkOutput("updAddr", cache_upd_addr, monE.addr);
            checkOutput("updData", cache_upd_data, monE.rdata);
          end
          if (monE.wupd) begin
            checkOutput("wupdAddr", cache_wupd_addr, monE.addr);
            checkOutput("wupdData", cache_wdata, monE.wdata);
            checkOutput("wupdMask", 64'(cache_wmask), 64'(monE.wmask));
          end
          if (monE.lat > 0) checkOutput("hitLatency", 64'(cyc - acceptCyc), 64'(monE.lat));
        end
      end else if (cache_upd || cache_wupd) begin
        checkOutput("strobeWithoutResp", 64'd1, 64'd0);
      end
      if (cache_upd) begin
        monIdx = modelFind(cache_upd_addr);
        if (monIdx < 0) begin
          monIdx = mNext;
          mNext  = (mNext + 1) % 4;
        end
        mValid[monIdx] = 1'b1;
        mAddr[monIdx]  = cache_upd_addr;
        mData[monIdx]  = cache_upd_data;
      end
      if (cache_wupd) begin
        monIdx = modelFind(cache_wupd_addr);
        if (monIdx >= 0) begin
          for (int b = 0; b < 8; b++) begin
            if (cache_wmask[b]) mData[monIdx][b*8 +: 8] = cache_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Memory model: optional request stall, then a single-cycle response memDelay cycles later.
  initial begin
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (memCd > 0) begin
        memCd--;
        if (memCd == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = memData;
        end
      end
      if (mem_req_valid) begin
        memValidCycles++;
        if (prevMemValid) begin
          checkOutput("stallAddr", mem_req_addr, snapAddr);
          checkOutput("stallWrite", 64'(mem_req_write), 64'(snapWrite));
          checkOutput("stallWdata", mem_req_wdata, snapWdata);
          checkOutput("stallWmask", 64'(mem_req_wmask), 64'(snapWmask));
        end else begin
          snapAddr  = mem_req_addr;
          snapWrite = mem_req_write;
          snapWdata = mem_req_wdata;
          snapWmask = mem_req_wmask;
        end
        if (stallLeft > 0) begin
          mem_req_ready = 1'b0;
          stallLeft--;
        end else begin
          mem_req_ready = 1'b1;
        end
        if (mem_req_ready) begin
          memReqCount++;
          lastMemAddr  = mem_req_addr;
          lastMemWrite = mem_req_write;
          lastMemWdata = mem_req_wdata;
          lastMemWmask = mem_req_wmask;
          memCd        = memDelay;
        end
      end else begin
        mem_req_ready = 1'b1;
      end
      prevMemValid = mem_req_valid && !mem_req_ready;
    end
  end

  task automatic applyStimulus(input logic w, input logic [63:0] a, input logic [63:0] wd,
                               input logic [7:0] m, input int stall);
    exp_t e;
    int   idx;
    int   n;
    idx     = modelFind(a);
    e.rdata = w ? 64'd0 : ((idx >= 0) ? mData[idx] : memData);
    e.upd   = !w && (idx < 0);
    e.wupd  = w && (idx >= 0);
    e.addr  = a;
    e.wdata = wd;
    e.wmask = m;
    e.lat   = (!w && (idx >= 0)) ? 2 : 0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) checkOutput("readyTimeout", 64'd0, 64'd1);
    stallLeft = stall;
    expQ.push_back(e);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    req_wmask = m;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput("respTimeout", 64'd0, 64'd1);
      expQ.delete();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n0, u0, w0, r0, mr, n;
    for (int i = 0; i < 4; i++) begin
      mValid[i] = 1'b0;
      mAddr[i]  = '0;
      mData[i]  = '0;
    end
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    req_wmask      = '0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("rstReqReady", 64'(req_ready), 64'd1);
    checkOutput("rstRespValid", 64'(resp_valid), 64'd0);
    checkOutput("rstMemValid", 64'(mem_req_valid), 64'd0);
    checkOutput("rstCacheUpd", 64'(cache_upd), 64'd0);
    checkOutput("rstCacheWupd", 64'(cache_wupd), 64'd0);
    checkOutput("rstRdata", resp_rdata, 64'd0);
    checkOutput("rstHitCnt", 64'(hit_cnt), 64'd0);
    checkOutput("rstMissCnt", 64'(miss_cnt), 64'd0);

    // Cold load miss with a refill.
    memData  = 64'hDEADBEEF_CAFEF00D;
    memDelay = 3;
    u0 = updCount;
    applyStimulus(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0);
    checkOutput("missMemAddr", lastMemAddr, 64'h8000_0010);
    checkOutput("missMemWrite", 64'(lastMemWrite), 64'd0);
    checkOutput("missUpdPulses", 64'(updCount - u0), 64'd1);
    checkOutput("missCnt1", 64'(miss_cnt), 64'd1);
    checkOutput("hitCnt0", 64'(hit_cnt), 64'd0);

    // Same load now hits in the model cache.
    n0 = memValidCycles;
    applyStimulus(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0);
    checkOutput("hitNoMemReq", 64'(memValidCycles - n0), 64'd0);
    checkOutput("hitCnt1", 64'(hit_cnt), 64'd1);

    // Store hit with a 4-cycle request stall.
    n0 = memValidCycles;
    w0 = wupdCount;
    applyStimulus(1'b1, 64'h8000_0010, 64'h11, 8'h01, 4);
    checkOutput("stMemAddr", lastMemAddr, 64'h8000_0010);
    checkOutput("stMemWrite", 64'(lastMemWrite), 64'd1);
    checkOutput("stMemWdata", lastMemWdata, 64'h11);
    checkOutput("stMemWmask", 64'(lastMemWmask), 64'h01);
    checkOutput("stStallCycles", 64'(memValidCycles - n0), 64'd5);
    checkOutput("stWupdPulses", 64'(wupdCount - w0), 64'd1);
    checkOutput("hitCnt2", 64'(hit_cnt), 64'd2);

    // Store miss: write-through only, no cache write.
    u0 = updCount;
    w0 = wupdCount;
    applyStimulus(1'b1, 64'h8000_0100, 64'hA5A5_0000_0000_0000, 8'hF0, 0);
    checkOutput("smMemAddr", lastMemAddr, 64'h8000_0100);
    checkOutput("smMemWrite", 64'(lastMemWrite), 64'd1);
    checkOutput("smMemWmask", 64'(lastMemWmask), 64'hF0);
    checkOutput("smNoUpd", 64'(updCount - u0), 64'd0);
    checkOutput("smNoWupd", 64'(wupdCount - w0), 64'd0);
    checkOutput("missCnt2", 64'(miss_cnt), 64'd2);

    // Unaligned load miss: memory address drops the byte offset.
    memData = 64'h0123_4567_89AB_CDEF;
    applyStimulus(1'b0, 64'h8000_0307, 64'd0, 8'h00, 0);
    checkOutput("alignMemAddr", lastMemAddr, 64'h8000_0300);
    checkOutput("missCnt3", 64'(miss_cnt), 64'd3);

    // Reset while waiting on memory; the late response must be ignored.
    memDelay = 6;
    memData  = 64'h5555_AAAA_5555_AAAA;
    r0 = respCount;
    u0 = updCount;
    mr = memReqCount;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 64'h8000_0400;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (memReqCount == mr && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("abortMemIssued", 64'(memReqCount - mr), 64'd1);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("abortReqReady", 64'(req_ready), 64'd1);
    checkOutput("abortHitCnt", 64'(hit_cnt), 64'd0);
    checkOutput("abortMissCnt", 64'(miss_cnt), 64'd0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    checkOutput("abortNoResp", 64'(respCount - r0), 64'd0);
    checkOutput("abortNoUpd", 64'(updCount - u0), 64'd0);
    checkOutput("abortMemIdle", 64'(mem_req_valid), 64'd0);
    memDelay = 3;

    // Five hitting loads saturate the 2-bit hit counter at 3.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0);
      checkOutput("satHitCnt", 64'(hit_cnt), 64'((i + 1 > 3) ? 3 : i + 1));
    end
    checkOutput("satMissCnt", 64'(miss_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
